// File: rtl/kanagawa_simple_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : kanagawa_simple_dual_port_ram
// Description : Simple dual-port RAM (one write port, one read port, one clock)
//               with optional write-first bypass and optional output register.
//               Define KANAGAWA_RAM_INIT_ZERO_EN to zero the array at power-up.
// Revision    : 1.0 - initial release
// ============================================================================
module kanagawa_simple_dual_port_ram #(
    parameter int    DATA_WIDTH       = 32,
    parameter int    ADDR_WIDTH       = 10,
    parameter int    USE_LUTRAM       = 0,
    parameter int    USE_BRAM         = 1,
    parameter int    USE_OUTPUT_REG   = 0,
    parameter int    NUM_BYPASS_SLOTS = 1,
    parameter string DEVICE_FAMILY    = "Stratix10"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rden_in,
    input  logic [ADDR_WIDTH-1:0] readaddr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  wren_in,
    input  logic [ADDR_WIDTH-1:0] writeaddr_in,
    input  logic [DATA_WIDTH-1:0] data_in
);

    localparam int c_DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit c_IS_XILINX = (DEVICE_FAMILY == "Virtex")     ||
                                 (DEVICE_FAMILY == "Kintex")     ||
                                 (DEVICE_FAMILY == "Artix")      ||
                                 (DEVICE_FAMILY == "Zynq")       ||
                                 (DEVICE_FAMILY == "UltraScale") ||
                                 (DEVICE_FAMILY == "Versal");

    generate
        if ((USE_LUTRAM != 0) && (USE_BRAM != 0)) begin : g_err_style
            $error("kanagawa_simple_dual_port_ram: USE_LUTRAM and USE_BRAM are mutually exclusive");
        end
        if ((NUM_BYPASS_SLOTS < 0) || (NUM_BYPASS_SLOTS > 1)) begin : g_err_bypass
            $error("kanagawa_simple_dual_port_ram: NUM_BYPASS_SLOTS must be 0 or 1");
        end
    endgenerate

    // Writes are dropped while reset is held; the array itself is never cleared.
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_wr_en = wren_in & rst;

    generate
        if ((USE_LUTRAM != 0) && c_IS_XILINX) begin : g_mem_distributed
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [c_DEPTH];
`ifdef KANAGAWA_RAM_INIT_ZERO_EN
            initial mem = '{default: '0};
`endif
            always_ff @(posedge clk) begin
                if (w_wr_en) mem[writeaddr_in] <= data_in;
            end
            assign w_mem_rdata = mem[readaddr_in];
        end else if (USE_LUTRAM != 0) begin : g_mem_mlab
            (* ramstyle = "MLAB" *) logic [DATA_WIDTH-1:0] mem [c_DEPTH];
`ifdef KANAGAWA_RAM_INIT_ZERO_EN
            initial mem = '{default: '0};
`endif
            always_ff @(posedge clk) begin
                if (w_wr_en) mem[writeaddr_in] <= data_in;
            end
            assign w_mem_rdata = mem[readaddr_in];
        end else if ((USE_BRAM != 0) && c_IS_XILINX) begin : g_mem_block
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [c_DEPTH];
`ifdef KANAGAWA_RAM_INIT_ZERO_EN
            initial mem = '{default: '0};
`endif
            always_ff @(posedge clk) begin
                if (w_wr_en) mem[writeaddr_in] <= data_in;
            end
            assign w_mem_rdata = mem[readaddr_in];
        end else if (USE_BRAM != 0) begin : g_mem_m20k
            (* ramstyle = "M20K" *) logic [DATA_WIDTH-1:0] mem [c_DEPTH];
`ifdef KANAGAWA_RAM_INIT_ZERO_EN
            initial mem = '{default: '0};
`endif
            always_ff @(posedge clk) begin
                if (w_wr_en) mem[writeaddr_in] <= data_in;
            end
            assign w_mem_rdata = mem[readaddr_in];
        end else begin : g_mem_auto
            logic [DATA_WIDTH-1:0] mem [c_DEPTH];
`ifdef KANAGAWA_RAM_INIT_ZERO_EN
            initial mem = '{default: '0};
`endif
            always_ff @(posedge clk) begin
                if (w_wr_en) mem[writeaddr_in] <= data_in;
            end
            assign w_mem_rdata = mem[readaddr_in];
        end
    endgenerate

    // First read stage: samples the array only on enabled reads (read-first on collision).
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] w_stage1;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rden_in) rd_data_d = w_mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data_q <= '0;
        else      rd_data_q <= rd_data_d;
    end

    generate
        if (NUM_BYPASS_SLOTS == 1) begin : g_bypass
            // Bypass state only moves with rden_in so a held read stays held.
            logic                  byp_valid_q;
            logic                  byp_valid_d;
            logic [DATA_WIDTH-1:0] byp_data_q;
            logic [DATA_WIDTH-1:0] byp_data_d;

            always_comb begin
                byp_valid_d = byp_valid_q;
                byp_data_d  = byp_data_q;
                if (rden_in) begin
                    byp_valid_d = wren_in && (writeaddr_in == readaddr_in);
                    byp_data_d  = data_in;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    byp_valid_q <= 1'b0;
                    byp_data_q  <= '0;
                end else begin
                    byp_valid_q <= byp_valid_d;
                    byp_data_q  <= byp_data_d;
                end
            end

            assign w_stage1 = byp_valid_q ? byp_data_q : rd_data_q;
        end else begin : g_no_bypass
            assign w_stage1 = rd_data_q;
        end
    endgenerate

    generate
        if (USE_OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) out_q <= '0;
                else      out_q <= w_stage1;
            end

            assign data_out = out_q;
        end else begin : g_out_direct
            assign data_out = w_stage1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_kanagawa_simple_dual_port_ram.sv
`default_nettype none
// Bench for kanagawa_simple_dual_port_ram: three instances (write-first,
// read-first, output-registered) share one stimulus stream and a scoreboard.
module tb_kanagawa_simple_dual_port_ram;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          rden_in;
    logic [AW-1:0] readaddr_in;
    logic          wren_in;
    logic [AW-1:0] writeaddr_in;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out_wf;
    logic [DW-1:0] data_out_rf;
    logic [DW-1:0] data_out_or;

    always #5 clk = ~clk;

    kanagawa_simple_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut_wf (
        .clk(clk), .rst(rst), .rden_in(rden_in), .readaddr_in(readaddr_in),
        .data_out(data_out_wf), .wren_in(wren_in), .writeaddr_in(writeaddr_in),
        .data_in(data_in)
    );

    kanagawa_simple_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                                    .NUM_BYPASS_SLOTS(0)) dut_rf (
        .clk(clk), .rst(rst), .rden_in(rden_in), .readaddr_in(readaddr_in),
        .data_out(data_out_rf), .wren_in(wren_in), .writeaddr_in(writeaddr_in),
        .data_in(data_in)
    );

    kanagawa_simple_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                                    .USE_OUTPUT_REG(1)) dut_or (
        .clk(clk), .rst(rst), .rden_in(rden_in), .readaddr_in(readaddr_in),
        .data_out(data_out_or), .wren_in(wren_in), .writeaddr_in(writeaddr_in),
        .data_in(data_in)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem_m [0:(1<<AW)-1];
    logic [DW-1:0] q_wf [$];
    logic [DW-1:0] q_rf [$];
    logic [DW-1:0] q_or [$];
    logic [DW-1:0] cur_wf;
    logic [DW-1:0] cur_rf;

    // One clock cycle: drive, predict, clock, then compare all three outputs.
    task automatic step(input logic rd, input logic [AW-1:0] ra, input logic wr,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input string tag);
        logic [DW-1:0] exp_or;
        rden_in      = rd;
        readaddr_in  = ra;
        wren_in      = wr;
        writeaddr_in = wa;
        data_in      = wd;
        if (rst && rd) begin
            q_wf.push_back((wr && (wa == ra)) ? wd : mem_m[ra]);
            q_rf.push_back(mem_m[ra]);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            cur_wf = '0;
            cur_rf = '0;
            q_wf.delete();
            q_rf.delete();
            q_or.delete();
            q_or.push_back('0);
            exp_or = '0;
        end else begin
            if (wr) mem_m[wa] = wd;
            if (rd) begin
                cur_wf = q_wf.pop_front();
                cur_rf = q_rf.pop_front();
            end
            q_or.push_back(cur_wf);
            exp_or = q_or.pop_front();
        end
        total += 3;
        if (data_out_wf !== cur_wf) begin
            bad++;
            $display("FAIL %s wf: got %h want %h", tag, data_out_wf, cur_wf);
        end
        if (data_out_rf !== cur_rf) begin
            bad++;
            $display("FAIL %s rf: got %h want %h", tag, data_out_rf, cur_rf);
        end
        if (data_out_or !== exp_or) begin
            bad++;
            $display("FAIL %s or: got %h want %h", tag, data_out_or, exp_or);
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, 1'b0, '0, '0, tag);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) idle("reset");
        rst = 1'b1;
        idle("post_reset");
    endtask

    task automatic test_basic_rw();
        step(1'b0, '0, 1'b1, 10'd5, 32'h0000_1234, "basic_wr");
        step(1'b1, 10'd5, 1'b0, '0, '0, "basic_rd");
        idle("basic_drain");
    endtask

    task automatic test_collision();
        step(1'b0, '0, 1'b1, 10'd7, 32'hAAAA_AAAA, "coll_init");
        idle("coll_gap");
        step(1'b1, 10'd7, 1'b1, 10'd7, 32'h5555_5555, "coll_rw");
        step(1'b1, 10'd7, 1'b0, '0, '0, "coll_after");
        idle("coll_drain");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            step(1'b0, '0, 1'b1, AW'(i), 32'h1000_0140 + DW'(i), "b2b_wr");
        for (int i = 0; i < 10; i++)
            step(1'b1, AW'(i), 1'b1, AW'(100 + i), 32'hC0DE_0000 + DW'(i), "b2b_rd");
        idle("b2b_drain");
        idle("b2b_drain");
    endtask

    task automatic test_output_reg();
        step(1'b0, '0, 1'b1, 10'd3, 32'hDEAD_BEEF, "oreg_wr");
        step(1'b1, 10'd3, 1'b0, '0, '0, "oreg_rd");
        idle("oreg_lat1");
        idle("oreg_lat2");
    endtask

    task automatic test_read_hold();
        step(1'b0, '0, 1'b1, 10'd9, 32'h0000_1234, "hold_wr");
        step(1'b1, 10'd9, 1'b0, '0, '0, "hold_rd");
        step(1'b0, 10'd9, 1'b1, 10'd9, 32'h0000_9999, "hold_overwrite");
        idle("hold_keep");
        step(1'b1, 10'd9, 1'b0, '0, '0, "hold_reread");
        idle("hold_drain");
    endtask

    task automatic test_async_reset();
        step(1'b1, 10'd100, 1'b1, 10'd11, 32'h7777_0000, "ares_pre");
        step(1'b1, 10'd101, 1'b0, '0, '0, "ares_pre2");
        #2 rst = 1'b0;
        #1;
        total += 3;
        if (data_out_wf !== '0) begin
            bad++;
            $display("FAIL ares_async wf: got %h want %h", data_out_wf, 32'h0);
        end
        if (data_out_rf !== '0) begin
            bad++;
            $display("FAIL ares_async rf: got %h want %h", data_out_rf, 32'h0);
        end
        if (data_out_or !== '0) begin
            bad++;
            $display("FAIL ares_async or: got %h want %h", data_out_or, 32'h0);
        end
        for (int i = 0; i < 3; i++)
            step(1'b1, 10'd5, 1'b1, 10'd5, 32'hBAD0_BAD0, "ares_in_reset");
        rst = 1'b1;
        step(1'b1, 10'd5, 1'b0, '0, '0, "ares_rd5");
        step(1'b1, 10'd11, 1'b0, '0, '0, "ares_rd11");
        step(1'b1, 10'd9, 1'b0, '0, '0, "ares_rd9");
        idle("ares_drain");
        idle("ares_drain");
    endtask

    task automatic test_init_zero();
`ifdef KANAGAWA_RAM_INIT_ZERO_EN
        step(1'b1, 10'd500, 1'b0, '0, '0, "init_zero_rd");
        idle("init_zero_drain");
        idle("init_zero_drain");
`endif
    endtask

    initial begin
`ifdef KANAGAWA_RAM_INIT_ZERO_EN
        for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
`endif
        cur_wf       = '0;
        cur_rf       = '0;
        rst          = 1'b0;
        rden_in      = 1'b0;
        readaddr_in  = '0;
        wren_in      = 1'b0;
        writeaddr_in = '0;
        data_in      = '0;
        q_or.push_back('0);

        test_reset();
        test_basic_rw();
        test_collision();
        test_back_to_back();
        test_output_reg();
        test_read_hold();
        test_async_reset();
        test_init_zero();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
